// File: rtl/mem_stage_if.sv
// Data-memory req/ack port between the MEM stage (master) and memory (slave).
interface mem_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// MEM stage: variable-latency load/store with timeout, owns the MEM/WB register.
// Optional MEM_ALIGN_CHECK_EN suppresses misaligned accesses and flags bus_error.
module mem_stage #(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  WriteRegM,
  mem_stage_if.master bus,
  output logic        StallM,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [4:0]  WriteRegW,
  output logic        bus_error
);

  typedef enum logic {IDLE, WAIT} state_e;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        rw_q, rw_d;
  logic        m2r_q, m2r_d;
  logic [31:0] rd_q, rd_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  wr_q, wr_d;

  logic acc, is_load, misal;
  logic req, stall;
  logic take, bubble, kill;
  logic ld_rdata, ld_err;

  assign acc     = MemtoRegM | MemWriteM;
  assign is_load = MemtoRegM & ~MemWriteM;

`ifdef MEM_ALIGN_CHECK_EN
  assign misal = acc & (ALUOutM[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif

  assign bus.mem_we    = MemWriteM;
  assign bus.mem_addr  = {ALUOutM[31:2], 2'b00};
  assign bus.mem_wdata = WriteDataM;

  // Gate with reset so a dropped access releases the bus at once
  assign bus.mem_req = req & ~reset;
  assign StallM      = stall & ~reset;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    req      = 1'b0;
    stall    = 1'b0;
    take     = 1'b0;
    bubble   = 1'b0;
    kill     = 1'b0;
    ld_rdata = 1'b0;
    ld_err   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!acc) begin
          take = 1'b1;
        end else if (misal) begin
          take   = 1'b1;
          kill   = 1'b1;
          err_d  = 1'b1;
          ld_err = is_load;
        end else begin
          req = 1'b1;
          if (bus.mem_ack) begin
            take     = 1'b1;
            ld_rdata = is_load;
          end else begin
            stall   = 1'b1;
            bubble  = 1'b1;
            state_d = WAIT;
            cnt_d   = 8'd1;
          end
        end
      end
      WAIT: begin
        req = 1'b1;
        if (bus.mem_ack) begin
          take     = 1'b1;
          ld_rdata = is_load;
          state_d  = IDLE;
          cnt_d    = 8'd0;
        end else if (cnt_q < TMO) begin
          stall  = 1'b1;
          bubble = 1'b1;
          cnt_d  = cnt_q + 8'd1;
        end else begin
          take    = 1'b1;
          err_d   = 1'b1;
          ld_err  = is_load;
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    rw_d  = rw_q;
    m2r_d = m2r_q;
    alu_d = alu_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (take) begin
      rw_d  = RegWriteM & ~kill;
      m2r_d = MemtoRegM;
      alu_d = ALUOutM;
      wr_d  = WriteRegM;
    end else if (bubble) begin
      rw_d  = 1'b0;
      m2r_d = 1'b0;
    end
    if (ld_rdata) begin
      rd_d = bus.mem_rdata;
    end else if (ld_err) begin
      rd_d = ERR_DATA;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
      rw_q    <= 1'b0;
      m2r_q   <= 1'b0;
      rd_q    <= 32'd0;
      alu_q   <= 32'd0;
      wr_q    <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rw_q    <= rw_d;
      m2r_q   <= m2r_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      wr_q    <= wr_d;
    end
  end

  assign RegWriteW = rw_q;
  assign MemtoRegW = m2r_q;
  assign ReadDataW = rd_q;
  assign ALUOutW   = alu_q;
  assign WriteRegW = wr_q;
  assign bus_error = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed plan steps plus random
// instructions scored against a transaction-level memory/latency model.
module tb_mem_stage;

  localparam int          TMO = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteM, MemtoRegM, MemWriteM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [4:0]  WriteRegM;
  logic        StallM, RegWriteW, MemtoRegW, bus_error;
  logic [31:0] ReadDataW, ALUOutW;
  logic [4:0]  WriteRegW;

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
    .clk(clk), .reset(reset),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
    .bus(bus.master),
    .StallM(StallM), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WriteRegW(WriteRegW),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  logic [31:0] mem_m [logic [31:0]];
  logic        err_m;
  logic [31:0] rd_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_w_zero(input string tag);
    chk({tag, ".RegWriteW"}, 32'(RegWriteW), 32'd0);
    chk({tag, ".MemtoRegW"}, 32'(MemtoRegW), 32'd0);
    chk({tag, ".ReadDataW"}, ReadDataW, 32'd0);
    chk({tag, ".ALUOutW"}, ALUOutW, 32'd0);
    chk({tag, ".WriteRegW"}, 32'(WriteRegW), 32'd0);
    chk({tag, ".bus_error"}, 32'(bus_error), 32'd0);
  endtask

  // One instruction; lat = request cycles before ack (> TMO means never acked)
  task automatic run(input string tag, input logic rw, input logic mtr, input logic mw,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [4:0] wr, input int lat);
    logic acc, ld, mis, ab;
    int done;
    logic [31:0] wa;
    acc = mtr | mw;
    ld  = mtr & ~mw;
    mis = ALIGN && acc && (addr[1:0] != 2'b00);
    wa  = {addr[31:2], 2'b00};
    if (ld && !mem_m.exists(wa)) mem_m[wa] = $urandom();
    done = (!acc || mis) ? 0 : ((lat <= TMO) ? lat : TMO);
    ab   = acc && !mis && (lat > TMO);
    RegWriteM  = rw;
    MemtoRegM  = mtr;
    MemWriteM  = mw;
    ALUOutM    = addr;
    WriteDataM = wd;
    WriteRegM  = wr;
    for (int c = 0; c <= done; c++) begin
      if (acc && !mis) bus.mem_ack = (c == lat);
      else             bus.mem_ack = ($urandom_range(0, 1) == 1);
      bus.mem_rdata = (acc && !mis && ld && c == lat) ? mem_m[wa] : $urandom();
      @(negedge clk);
      chk({tag, ".mem_req"}, 32'(bus.mem_req), 32'(acc && !mis));
      chk({tag, ".StallM"}, 32'(StallM), 32'(c < done));
      if (acc && !mis) begin
        chk({tag, ".mem_addr"}, bus.mem_addr, wa);
        chk({tag, ".mem_we"}, 32'(bus.mem_we), 32'(mw));
        chk({tag, ".mem_wdata"}, bus.mem_wdata, wd);
      end
      @(posedge clk);
      #1;
      if (c < done) begin
        chk({tag, ".bubble_rw"}, 32'(RegWriteW), 32'd0);
        chk({tag, ".bubble_m2r"}, 32'(MemtoRegW), 32'd0);
      end
    end
    bus.mem_ack = 1'b0;
    if (mw && acc && !mis && !ab) mem_m[wa] = wd;
    if (mis || ab) err_m = 1'b1;
    if (ld) rd_m = (mis || ab) ? ERR : mem_m[wa];
    chk({tag, ".RegWriteW"}, 32'(RegWriteW), 32'(rw && !mis));
    chk({tag, ".MemtoRegW"}, 32'(MemtoRegW), 32'(mtr));
    chk({tag, ".ALUOutW"}, ALUOutW, addr);
    chk({tag, ".WriteRegW"}, 32'(WriteRegW), 32'(wr));
    chk({tag, ".ReadDataW"}, ReadDataW, rd_m);
    chk({tag, ".bus_error"}, 32'(bus_error), 32'(err_m));
  endtask

  initial begin
    logic [31:0] a, d;
    int kind;
    reset = 1'b1;
    RegWriteM = 1'b0; MemtoRegM = 1'b0; MemWriteM = 1'b0;
    ALUOutM = 32'd0; WriteDataM = 32'd0; WriteRegM = 5'd0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
    err_m = 1'b0;
    rd_m  = 32'd0;
    #12;
    chk_w_zero("reset");
    chk("reset.mem_req", 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run("nonmem", 1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd8, 0);
    mem_m[32'h40] = 32'hCAFEBABE;
    run("ld0", 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd3, 0);
    run("st3", 1'b0, 1'b0, 1'b1, 32'h80, 32'h55, 5'd0, 3);
    run("ld_after_st", 1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 5'd4, 1);
    run("ld_ack_abort_cycle", 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd5, TMO);
    run("ld_timeout", 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 5'd6, 99);
    run("err_sticky", 1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 5'd7, 0);

    // Reset in the second WAIT cycle of a load
    RegWriteM = 1'b1; MemtoRegM = 1'b1; MemWriteM = 1'b0;
    ALUOutM = 32'h300; WriteRegM = 5'd9; bus.mem_ack = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("midwait.StallM_pre", 32'(StallM), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("midwait.mem_req", 32'(bus.mem_req), 32'd0);
    chk("midwait.StallM", 32'(StallM), 32'd0);
    chk_w_zero("midwait");
    err_m = 1'b0;
    rd_m  = 32'd0;
    RegWriteM = 1'b0; MemtoRegM = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run("post_reset_ld", 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd10, 2);

    run("misaligned_ld", 1'b1, 1'b1, 1'b0, 32'h42, 32'h0, 5'd11, 0);
    run("both_is_store", 1'b0, 1'b1, 1'b1, 32'h44, 32'hA5A5, 5'd0, 1);
    run("ld_both_result", 1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 5'd12, 0);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      a = $urandom_range(0, 15) << 2;
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      d = $urandom();
      case (kind)
        0: run("rnd_nop", 1'($urandom_range(0, 1)), 1'b0, 1'b0, d, 32'h0,
               5'($urandom_range(0, 31)), 0);
        1: run("rnd_ld", 1'b1, 1'b1, 1'b0, a, 32'h0,
               5'($urandom_range(1, 31)), $urandom_range(0, TMO + 1));
        2: run("rnd_st", 1'b0, 1'b0, 1'b1, a, d, 5'd0,
               $urandom_range(0, TMO + 1));
        default: run("rnd_both", 1'b0, 1'b1, 1'b1, a, d, 5'd0,
                     $urandom_range(0, TMO));
      endcase
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the pipelined MIPS CPU, directly downstream of EX.
- Consumes EX/MEM register outputs (RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM).
- Performs loads and stores over a variable-latency req/ack data-memory port.
- Raises StallM to the hazard unit while an access is outstanding; owns the MEM/WB pipeline register feeding WB.

Parameters:
- TIMEOUT, 16, maximum wait cycles after the request cycle before an access is aborted (range 1..255).
- ERR_DATA, 32'h0000_0000, value returned as ReadDataW for an aborted or suppressed load.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- RegWriteM  in  1  register write enable of the instruction in MEM
- MemtoRegM  in  1  instruction is a load
- MemWriteM  in  1  instruction is a store
- ALUOutM  in  32  effective address, or ALU result for non-memory instructions
- WriteDataM  in  32  store data
- WriteRegM  in  5  destination register
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  word address, {ALUOutM[31:2],2'b00}
- mem_wdata  out  32  store data
- mem_rdata  in  32  load data, valid with mem_ack
- mem_ack  in  1  access complete
- StallM  out  1  hold IF/ID/EX and the EX/MEM register
- RegWriteW, MemtoRegW  out  1 each  MEM/WB control
- ReadDataW, ALUOutW  out  32 each  MEM/WB data
- WriteRegW  out  5  MEM/WB destination register
- bus_error  out  1  sticky error flag (timeout or misalignment)

Behaviour:
- Reset (async): all W outputs 0, bus_error 0, FSM IDLE, wait counter 0. Outputs settle immediately on reset assertion.
- acc = MemtoRegM | MemWriteM. If both are set, treat the access as a store.
- mem_we = MemWriteM; mem_addr and mem_wdata are driven combinationally from the M inputs.
- FSM states: IDLE, WAIT.
- IDLE, acc=0:
  - mem_req=0, StallM=0.
  - Next edge: W register loads RegWriteM, MemtoRegM, ALUOutM, WriteRegM.
  - ReadDataW keeps its previous value.
- IDLE, acc=1:
  - mem_req=1 combinationally.
  - mem_ack=1 in the same cycle: zero-wait. StallM=0. W loads the instruction; ReadDataW<=mem_rdata on a load.
  - mem_ack=0: StallM=1, next state WAIT, counter<=1, W loads a bubble (RegWriteW=0, MemtoRegW=0).
- WAIT:
  - mem_req=1. Upstream holds the M inputs stable (guaranteed by StallM).
  - mem_ack=1: StallM=0, W loads the instruction and read data, next state IDLE.
  - mem_ack=0 and counter<TIMEOUT: StallM=1, counter+1, W loads a bubble.
  - mem_ack=0 and counter==TIMEOUT: abort. StallM=0, mem_req stays 1 this cycle, bus_error<=1. W loads the instruction with ReadDataW<=ERR_DATA (load) or a no-op (store; RegWrite is already 0). Next state IDLE.
- An ack arriving in the abort cycle counts as success. No error is flagged.
- A late mem_ack arriving in IDLE with acc=0 is ignored.
- bus_error stays set until reset.
- Reset asserted mid-WAIT: FSM returns to IDLE and mem_req drops immediately. The pending access is dropped; the memory side tolerates this.
- Throughput: one instruction per cycle when every access acks in zero wait.
- Latency: M to W is one edge after access completion.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined, and acc=1 with ALUOutM[1:0]!=0:
  - Access is suppressed: mem_req=0, no stall.
  - bus_error<=1 at the next edge.
  - W loads the instruction with RegWriteW forced to 0.
- Not defined: low address bits are ignored (truncated); no misalignment error exists.

Test Plan:
- Non-memory instruction: RegWriteM=1, ALUOutM=32'h1234, WriteRegM=5'd8 -> next edge RegWriteW=1, ALUOutW=32'h1234, WriteRegW=8; mem_req=0 throughout; StallM never high.
- Zero-wait load: MemtoRegM=1, ALUOutM=32'h40, same-cycle mem_ack with mem_rdata=32'hCAFEBABE -> mem_addr=32'h40, StallM=0, next edge ReadDataW=32'hCAFEBABE, MemtoRegW=1.
- Three-wait store: MemWriteM=1, addr 32'h80, data 32'h55; mem_ack on the 4th request cycle -> StallM high for 3 cycles, mem_we=1 throughout, RegWriteW=0 during the stall, then IDLE.
- Timeout with TIMEOUT=4, load, no ack -> StallM high 4 cycles, released in the 5th; bus_error=1; ReadDataW=ERR_DATA; bus_error stays set afterward.
- Reset in the 2nd WAIT cycle -> mem_req and StallM drop immediately, all W outputs 0, bus_error 0; next instruction proceeds normally.
- MEM_ALIGN_CHECK_EN defined, load from 32'h42 -> mem_req never asserts, bus_error=1, RegWriteW=0. Macro not defined -> mem_addr=32'h40 and the load completes normally.
